// File: rtl/ander_2_pkg.sv
// Shared elaboration limits for the ander_2 registered AND unit.
package ander_2_pkg;

  localparam int WIDTH_MAX   = 64;
  localparam int LATENCY_MAX = 4;

endpackage : ander_2_pkg

// File: rtl/ander_2_stage.sv
// One pipeline stage of ander_2: a data register that loads only on valid, plus a valid flop.
module ander_2_stage
  import ander_2_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic             valid_q;

  // Data only moves with a valid beat, so garbage on idle cycles never propagates.
  always_comb begin
    data_d  = data_q;
    valid_d = in_valid;
    if (in_valid) begin
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule : ander_2_stage

// File: rtl/ander_2.sv
// Bitwise 2-input AND with a LATENCY-deep valid-qualified pipeline and all/any reduction flags.
module ander_2
  import ander_2_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] res,
  output logic             out_valid,
  output logic             res_all,
  output logic             res_any
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("ander_2: WIDTH must be within 1..64");
  end

  if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("ander_2: LATENCY must be within 0..4");
  end

  // Tap 0 is the raw combinational product; tap k is the output of stage k.
  logic [WIDTH-1:0] data_tap  [LATENCY+1];
  logic             valid_tap [LATENCY+1];

  assign data_tap[0]  = a & b;
  assign valid_tap[0] = in_valid;

  if (LATENCY == 0) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end else begin : g_pipe
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      ander_2_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (data_tap[k]),
        .in_valid (valid_tap[k]),
        .out_data (data_tap[k+1]),
        .out_valid(valid_tap[k+1])
      );
    end
  end

  assign res       = data_tap[LATENCY];
  assign out_valid = valid_tap[LATENCY];
  assign res_all   = &res;
  assign res_any   = |res;

endmodule : ander_2

// File: tb/tb_ander_2.sv
// Directed and randomized bench for ander_2 across four WIDTH/LATENCY configurations.
module tb_ander_2;

  localparam int DEPTH = 2048;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=1, LATENCY=1
  logic [0:0] a1, b1, r1;
  logic       v1, ov1, ra1, ry1;
  // WIDTH=8, LATENCY=3
  logic [7:0] a3, b3, r3;
  logic       v3, ov3, ra3, ry3;
  // WIDTH=8, LATENCY=1 (hold test)
  logic [7:0] ah, bh, rh;
  logic       vh, ovh, rah, ryh;
  // WIDTH=4, LATENCY=0
  logic [3:0] a0, b0, r0;
  logic       v0, ov0, ra0, ry0;

  ander_2 #(.WIDTH(1), .LATENCY(1)) u_w1l1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .res(r1), .out_valid(ov1), .res_all(ra1), .res_any(ry1));
  ander_2 #(.WIDTH(8), .LATENCY(3)) u_w8l3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .in_valid(v3),
    .res(r3), .out_valid(ov3), .res_all(ra3), .res_any(ry3));
  ander_2 #(.WIDTH(8), .LATENCY(1)) u_w8l1 (
    .clk(clk), .rst_n(rst_n), .a(ah), .b(bh), .in_valid(vh),
    .res(rh), .out_valid(ovh), .res_all(rah), .res_any(ryh));
  ander_2 #(.WIDTH(4), .LATENCY(0)) u_w4l0 (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .in_valid(v0),
    .res(r0), .out_valid(ov0), .res_all(ra0), .res_any(ry0));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: per-instance log of (valid, a&b) sampled at each clock since reset.
  bit          hv [3][DEPTH];
  logic [63:0] hd [3][DEPTH];
  int          hn [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hn[0] <= 0;
      hn[1] <= 0;
      hn[2] <= 0;
    end else begin
      if (hn[0] < DEPTH) begin
        hv[0][hn[0]] <= v1;
        hd[0][hn[0]] <= 64'(a1 & b1);
        hn[0]        <= hn[0] + 1;
      end
      if (hn[1] < DEPTH) begin
        hv[1][hn[1]] <= v3;
        hd[1][hn[1]] <= 64'(a3 & b3);
        hn[1]        <= hn[1] + 1;
      end
      if (hn[2] < DEPTH) begin
        hv[2][hn[2]] <= vh;
        hd[2][hn[2]] <= 64'(ah & bh);
        hn[2]        <= hn[2] + 1;
      end
    end
  end

  // Output after n clocks: valid of sample n-lat; result of the latest valid sample at or before it.
  function automatic logic [64:0] model(input int id, input int lat);
    logic [64:0] r;
    int          idx;
    r   = '0;
    idx = hn[id] - lat;
    if (idx >= 0) begin
      r[64] = hv[id][idx];
      for (int j = idx; j >= 0; j--) begin
        if (hv[id][j]) begin
          r[63:0] = hd[id][j];
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pipe(input string tag, input int id, input int lat, input int w,
                          input logic [63:0] r, input logic ov, input logic ra, input logic ry);
    logic [64:0] e;
    logic [63:0] m;
    e = model(id, lat);
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    chk({tag, "_res"}, r, e[63:0]);
    chk({tag, "_vld"}, 64'(ov), 64'(e[64]));
    chk({tag, "_all"}, 64'(ra), 64'((e[63:0] & m) == m));
    chk({tag, "_any"}, 64'(ry), 64'((e[63:0] & m) != 64'd0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a1 = '0; b1 = '0; v1 = 1'b0;
    a3 = '0; b3 = '0; v3 = 1'b0;
    ah = '0; bh = '0; vh = 1'b0;
    a0 = '0; b0 = '0; v0 = 1'b0;

    #1 rst_n = 1'b0;
    tick();
    tick();
    chk_pipe("rst_w1l1", 0, 1, 1, 64'(r1), ov1, ra1, ry1);
    chk_pipe("rst_w8l3", 1, 3, 8, 64'(r3), ov3, ra3, ry3);
    chk_pipe("rst_w8l1", 2, 1, 8, 64'(rh), ovh, rah, ryh);
    chk("rst_w8l3_res_const", 64'(r3), 64'd0);
    chk("rst_w8l3_vld_const", 64'(ov3), 64'd0);
    rst_n = 1'b1;

    // WIDTH=1 truth table, each pair held 20 cycles
    for (int p = 0; p < 4; p++) begin
      a1 = p[0];
      b1 = p[1];
      v1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
        tick();
        chk_pipe("w1l1", 0, 1, 1, 64'(r1), ov1, ra1, ry1);
      end
      chk("w1l1_res_const", 64'(r1), 64'(p[0] & p[1]));
    end
    v1 = 1'b0;

    // LATENCY=3 single pulses
    a3 = 8'hF0; b3 = 8'h3C; v3 = 1'b1;
    tick();
    v3 = 1'b0; a3 = 8'($urandom); b3 = 8'($urandom);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk_pipe("l3_pulse", 1, 3, 8, 64'(r3), ov3, ra3, ry3);
      if (c == 3) begin
        chk("l3_pulse_res", 64'(r3), 64'h30);
        chk("l3_pulse_vld", 64'(ov3), 64'd1);
        chk("l3_pulse_all", 64'(ra3), 64'd0);
        chk("l3_pulse_any", 64'(ry3), 64'd1);
      end else begin
        chk("l3_pulse_idle_vld", 64'(ov3), 64'd0);
      end
    end
    a3 = 8'hFF; b3 = 8'hFF; v3 = 1'b1;
    tick();
    v3 = 1'b0; a3 = 8'($urandom); b3 = 8'($urandom);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk_pipe("l3_ones", 1, 3, 8, 64'(r3), ov3, ra3, ry3);
      if (c == 3) begin
        chk("l3_ones_res", 64'(r3), 64'hFF);
        chk("l3_ones_all", 64'(ra3), 64'd1);
      end
    end

    // LATENCY=3 random stream, including back-to-back valids
    for (int c = 0; c < 200; c++) begin
      a3 = 8'($urandom);
      b3 = 8'($urandom);
      v3 = ($urandom_range(0, 3) != 0);
      tick();
      chk_pipe("l3_rand", 1, 3, 8, 64'(r3), ov3, ra3, ry3);
    end
    v3 = 1'b0;

    // Hold: idle cycles with toggling or unknown operands must not disturb res
    ah = 8'hAA; bh = 8'hFF; vh = 1'b1;
    tick();
    chk("hold_load_res", 64'(rh), 64'hAA);
    chk("hold_load_vld", 64'(ovh), 64'd1);
    vh = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 1) begin
        ah = 'x;
        bh = 'x;
      end else begin
        ah = 8'($urandom);
        bh = 8'($urandom);
      end
      tick();
      chk("hold_res", 64'(rh), 64'hAA);
      chk("hold_vld", 64'(ovh), 64'd0);
      chk_pipe("hold", 2, 1, 8, 64'(rh), ovh, rah, ryh);
    end
    ah = '0; bh = '0;

    // Reset mid-stream on LATENCY=3
    v3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a3 = 8'($urandom) | 8'h01;
      b3 = 8'($urandom) | 8'h01;
      tick();
    end
    v3 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_res", 64'(r3), 64'd0);
    chk("midrst_vld", 64'(ov3), 64'd0);
    chk("midrst_all", 64'(ra3), 64'd0);
    chk("midrst_any", 64'(ry3), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("postrst_vld", 64'(ov3), 64'd0);
      chk_pipe("postrst", 1, 3, 8, 64'(r3), ov3, ra3, ry3);
    end
    a3 = 8'h5A; b3 = 8'hF3; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_pipe("postrst_first", 1, 3, 8, 64'(r3), ov3, ra3, ry3);
      if (c == 3) begin
        chk("postrst_first_res", 64'(r3), 64'h52);
        chk("postrst_first_vld", 64'(ov3), 64'd1);
      end
    end

    // LATENCY=0 is purely combinational
    a0 = 4'hC; b0 = 4'hA; v0 = 1'b1;
    #1;
    chk("l0_res", 64'(r0), 64'h8);
    chk("l0_vld", 64'(ov0), 64'd1);
    chk("l0_all", 64'(ra0), 64'd0);
    chk("l0_any", 64'(ry0), 64'd1);
    v0 = 1'b0;
    #1;
    chk("l0_vld_low", 64'(ov0), 64'd0);
    for (int c = 0; c < 30; c++) begin
      logic [3:0] e;
      a0 = 4'($urandom);
      b0 = 4'($urandom);
      v0 = 1'($urandom_range(0, 1));
      e  = a0 & b0;
      #1;
      chk("l0_rand_res", 64'(r0), 64'(e));
      chk("l0_rand_vld", 64'(ov0), 64'(v0));
      chk("l0_rand_all", 64'(ra0), 64'(e == 4'hF));
      chk("l0_rand_any", 64'(ry0), 64'(e != 4'h0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ander_2

// File: doc/ander_2.md
Name: ander_2

Overview:
- Registered bitwise 2-input AND unit: res = a & b, delivered through a configurable pipeline with a valid qualifier.
- Used as a leaf logic primitive wherever a gated or masked vector is needed with a predictable, fixed latency.
- Also provides all-ones and any-ones reduction flags of the result.

Parameters:
- WIDTH, 1, bit width of operands a, b and result res (legal 1..64).
- LATENCY, 1, number of register stages from inputs to outputs (legal 0..4). 0 makes the block purely combinational; clk and rst_n are then unused.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  a/b carry a valid operand pair this cycle.
- res  output  WIDTH  a & b, delayed LATENCY cycles.
- out_valid  output  1  in_valid delayed LATENCY cycles; qualifies res.
- res_all  output  1  AND-reduction of res (all bits 1).
- res_any  output  1  OR-reduction of res (any bit 1).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous assert):
  - All stage data registers clear to 0 and all valid bits clear to 0.
  - Hence res=0, res_all=0, out_valid=0, res_any=0 immediately.
  - Release is synchronous to the next rising clk edge.
- Stage 1 at each rising edge:
  - valid_1 <= in_valid.
  - data_1 <= a & b when in_valid=1; holds its previous value when in_valid=0.
- Stage k (k >= 2) at each rising edge:
  - valid_k <= valid_(k-1).
  - data_k <= data_(k-1) when valid_(k-1)=1; otherwise holds.
- Outputs:
  - res = data_LATENCY, out_valid = valid_LATENCY.
  - res_all = &res and res_any = |res, both combinational from the registered res (no extra stage).
- Latency is exactly LATENCY cycles. There is no backpressure and no stall, so throughput is one pair per cycle.
- LATENCY=0: res = a & b, out_valid = in_valid, all combinational.
- Bitwise semantics: res[i] = a[i] & b[i]. There is no carry and no width growth.
- Boundary conditions:
  - X on a or b while in_valid=0 must not reach res.
  - Back-to-back valids each appear on consecutive cycles.
  - Reset mid-stream drops all in-flight pairs; out_valid stays 0 until LATENCY cycles after the first post-reset in_valid.
  - WIDTH=1 gives res_all = res_any = res.

Decomposition:
- Shared package holds LATENCY_MAX=4 and WIDTH_MAX=64 for elaboration-time parameter range checks.
- One natural sub-module, ander_2_stage: a single WIDTH-wide data register with load-on-valid plus a valid flop, asynchronous active-low reset. Instantiate it LATENCY times via a generate loop.

Test Plan:
- WIDTH=1, LATENCY=1: apply (a,b)=(0,0),(1,0),(0,1),(1,1), each held 200 ns with in_valid=1 -> res = 0,0,0,1 one cycle after each change; res_all = res_any = res.
- WIDTH=8, LATENCY=3: a=0xF0, b=0x3C with one in_valid pulse -> after exactly 3 cycles res=0x30, out_valid=1 for one cycle, res_all=0, res_any=1. Follow with a=b=0xFF -> res=0xFF, res_all=1.
- Hold test, WIDTH=8, LATENCY=1: load 0xAA&0xFF, then drive in_valid=0 while a/b toggle randomly -> res stays 0xAA and out_valid=0.
- Reset mid-stream, LATENCY=3: three back-to-back valid pairs, assert rst_n=0 between clock edges -> res=0 and out_valid=0 immediately, with no stale result after release.
- LATENCY=0, WIDTH=4: a=0xC, b=0xA -> res=0x8 in the same cycle, out_valid follows in_valid combinationally.
